// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Decode, forwarding-source and EX-stage signals of the ID/EX
//               pipeline register, bundled for connection to id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    // pipeline control
    logic             stall;
    logic             flush;
    logic             hazard_stall;

    // decode slot
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [RADDR-1:0] id_rs1;
    logic [RADDR-1:0] id_rs2;
    logic [RADDR-1:0] id_rd;
    logic [2:0]       id_alu_control;
    logic             id_alu_a_pc;
    logic             id_alu_b_imm;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;

    // forwarding sources
    logic [RADDR-1:0] mem_rd;
    logic             mem_reg_write;
    logic [XLEN-1:0]  mem_result;
    logic [RADDR-1:0] wb_rd;
    logic             wb_reg_write;
    logic [XLEN-1:0]  wb_data;

    // EX stage
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [RADDR-1:0] ex_rd;
    logic [2:0]       ex_alu_control;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  ex_store_data;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;

    modport master (
        output stall, flush,
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_alu_control, id_alu_a_pc, id_alu_b_imm,
        output id_reg_write, id_mem_read, id_mem_write,
        output mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
        input  hazard_stall,
        input  ex_valid, ex_pc, ex_imm, ex_rd, ex_alu_control,
        input  alu_a, alu_b, ex_store_data,
        input  ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd, id_alu_control, id_alu_a_pc, id_alu_b_imm,
        input  id_reg_write, id_mem_read, id_mem_write,
        input  mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
        output hazard_stall,
        output ex_valid, ex_pc, ex_imm, ex_rd, ex_alu_control,
        output alu_a, alu_b, ex_store_data,
        output ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with EX-stage operand forwarding and
//               load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    id_ex_stage_if.slave  bus
);

    localparam logic [RADDR-1:0] c_reg_zero = '0;

    // ------------------------------------------------------------------------
    // EX-stage registers
    // ------------------------------------------------------------------------
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    logic [RADDR-1:0] r_rs1;
    logic [RADDR-1:0] r_rs2;
    logic [XLEN-1:0]  r_rs1_val;
    logic [XLEN-1:0]  r_rs2_val;
    logic [RADDR-1:0] r_rd;
    logic [2:0]       r_alu_control;
    logic             r_alu_a_pc;
    logic             r_alu_b_imm;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;

    logic             w_hazard;
    logic             w_bubble;
    logic [XLEN-1:0]  w_id_rs1_val;
    logic [XLEN-1:0]  w_id_rs2_val;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    // A load in EX whose destination is read by the decode instruction cannot
    // be forwarded in time; hold decode for one cycle and insert a bubble.
    assign w_hazard = r_valid && r_mem_read && (r_rd != c_reg_zero) &&
                      bus.id_valid && !bus.flush &&
                      ((r_rd == bus.id_rs1) || (r_rd == bus.id_rs2));

    assign w_bubble = bus.flush || w_hazard;

    // ------------------------------------------------------------------------
    // Decode-side bypass of a regfile write happening in the same cycle
    // ------------------------------------------------------------------------
    always_comb begin
        w_id_rs1_val = bus.id_rs1_data;
        if (bus.wb_reg_write && (bus.wb_rd != c_reg_zero) && (bus.wb_rd == bus.id_rs1)) begin
            w_id_rs1_val = bus.wb_data;
        end
    end

    always_comb begin
        w_id_rs2_val = bus.id_rs2_data;
        if (bus.wb_reg_write && (bus.wb_rd != c_reg_zero) && (bus.wb_rd == bus.id_rs2)) begin
            w_id_rs2_val = bus.wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline register: stall > flush/hazard bubble > load
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rs1_val     <= '0;
            r_rs2_val     <= '0;
            r_rd          <= '0;
            r_alu_control <= 3'b000;
            r_alu_a_pc    <= 1'b0;
            r_alu_b_imm   <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else if (bus.stall) begin
            r_valid       <= r_valid;
        end else if (w_bubble) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rs1_val     <= '0;
            r_rs2_val     <= '0;
            r_rd          <= '0;
            r_alu_control <= 3'b000;
            r_alu_a_pc    <= 1'b0;
            r_alu_b_imm   <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            r_valid       <= bus.id_valid;
            r_pc          <= bus.id_pc;
            r_imm         <= bus.id_imm;
            r_rs1         <= bus.id_rs1;
            r_rs2         <= bus.id_rs2;
            r_rs1_val     <= w_id_rs1_val;
            r_rs2_val     <= w_id_rs2_val;
            r_rd          <= bus.id_rd;
            r_alu_control <= bus.id_alu_control;
            r_alu_a_pc    <= bus.id_alu_a_pc;
            r_alu_b_imm   <= bus.id_alu_b_imm;
            r_reg_write   <= bus.id_reg_write && bus.id_valid;
            r_mem_read    <= bus.id_mem_read  && bus.id_valid;
            r_mem_write   <= bus.id_mem_write && bus.id_valid;
        end
    end

    // ------------------------------------------------------------------------
    // EX-stage forwarding; the younger EX/MEM result beats MEM/WB
    // ------------------------------------------------------------------------
    always_comb begin
        w_fwd_rs1 = r_rs1_val;
        if (bus.mem_reg_write && (bus.mem_rd != c_reg_zero) && (bus.mem_rd == r_rs1)) begin
            w_fwd_rs1 = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_rd != c_reg_zero) && (bus.wb_rd == r_rs1)) begin
            w_fwd_rs1 = bus.wb_data;
        end
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_val;
        if (bus.mem_reg_write && (bus.mem_rd != c_reg_zero) && (bus.mem_rd == r_rs2)) begin
            w_fwd_rs2 = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_rd != c_reg_zero) && (bus.wb_rd == r_rs2)) begin
            w_fwd_rs2 = bus.wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.hazard_stall   = w_hazard;
    assign bus.ex_valid       = r_valid;
    assign bus.ex_pc          = r_pc;
    assign bus.ex_imm         = r_imm;
    assign bus.ex_rd          = r_rd;
    assign bus.ex_alu_control = r_alu_control;
    assign bus.ex_reg_write   = r_reg_write;
    assign bus.ex_mem_read    = r_mem_read;
    assign bus.ex_mem_write   = r_mem_write;

    assign bus.alu_a          = r_alu_a_pc  ? r_pc  : w_fwd_rs1;
    assign bus.alu_b          = r_alu_b_imm ? r_imm : w_fwd_rs2;
    // Stores always need the register value, even when B carries the offset.
    assign bus.ex_store_data  = w_fwd_rs2;

endmodule
`default_nettype wire
